// File: rtl/spi_controller_pkg.sv
// Shared types and helpers for the SPI register command sequencer.
// Latency: none (types and a combinational helper only).
// Backpressure: not applicable.
package spi_controller_pkg;

  localparam int SPI_BYTE_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE,
    XFER,
    RESP
  } spi_register_controller_state_t;

  // Address byte on the wire is {rw_bit, addr}; writes use the inverse of the read marker.
  function automatic logic [SPI_BYTE_WIDTH-1:0] build_addr_byte(
    input logic                      is_write,
    input logic                      read_bit_value,
    input logic [SPI_BYTE_WIDTH-2:0] addr
  );
    return {(is_write ? ~read_bit_value : read_bit_value), addr};
  endfunction

endpackage

// File: rtl/spi_register_controller.sv
// Turns one register read/write command into a {addr, data...} byte frame for spi_master and gathers the reply.
// Latency: rsp_valid one cycle after the last miso byte; timeout aborts TIMEOUT_CYCLES cycles after the last miso byte.
// Backpressure: mosi bytes wait on mosi_tready with tdata held; miso is always accepted; response holds until rsp_ready.
module spi_register_controller
  import spi_controller_pkg::*;
#(
  parameter int   ADDR_WIDTH     = 7,
  parameter int   DATA_BYTES     = 2,
  parameter logic READ_BIT_VALUE = 1'b1,
  parameter int   TIMEOUT_CYCLES = 4096
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                cmd_valid,
  output logic                                cmd_ready,
  input  logic                                cmd_write,
  input  logic [ADDR_WIDTH-1:0]               cmd_addr,
  input  logic [SPI_BYTE_WIDTH*DATA_BYTES-1:0] cmd_wdata,
  output logic                                rsp_valid,
  input  logic                                rsp_ready,
  output logic [SPI_BYTE_WIDTH*DATA_BYTES-1:0] rsp_rdata,
  output logic                                rsp_error,
  output logic [SPI_BYTE_WIDTH-1:0]           mosi_tdata,
  output logic                                mosi_tvalid,
  input  logic                                mosi_tready,
  output logic                                mosi_tkeep,
  output logic                                mosi_tlast,
  output logic                                mosi_tid,
  output logic                                mosi_tdest,
  output logic                                mosi_tuser,
  input  logic [SPI_BYTE_WIDTH-1:0]           miso_tdata,
  input  logic                                miso_tvalid,
  output logic                                miso_tready
);

  localparam int NBYTES = DATA_BYTES + 1;
  localparam int DW     = SPI_BYTE_WIDTH * DATA_BYTES;
  localparam int SRW    = SPI_BYTE_WIDTH * NBYTES;
  localparam int CW     = $clog2(NBYTES + 1);
  localparam int TW     = $clog2(TIMEOUT_CYCLES);

  spi_register_controller_state_t state_q, state_d;

  logic [SRW-1:0] tx_sr_q;
  logic [DW-1:0]  rdata_q;
  logic [CW-1:0]  tx_cnt_q;
  logic [CW-1:0]  rx_cnt_q;
  logic [TW-1:0]  timer_q;
  logic           write_q;
  logic           error_q;
  logic           mosi_hs;
  logic           miso_hs;
  logic           rx_last;
  logic           timeout;
  logic [DW-1:0]  wdata_sel;

  assign mosi_hs     = mosi_tvalid && mosi_tready;
  assign miso_hs     = miso_tvalid && miso_tready;
  assign miso_tready = 1'b1;
  assign mosi_tdata  = tx_sr_q[SRW-1 -: SPI_BYTE_WIDTH];
  assign mosi_tkeep  = 1'b1;
  assign mosi_tlast  = 1'b1;
  assign mosi_tid    = 1'b0;
  assign mosi_tdest  = 1'b0;
  assign mosi_tuser  = 1'b0;
  assign rsp_rdata   = (state_q == RESP) ? rdata_q : '0;
  assign rsp_error   = (state_q == RESP) && error_q;
  assign wdata_sel   = cmd_write ? cmd_wdata : DW'(0);

  // Next state, handshake outputs and the end-of-transfer / timeout decisions.
  always_comb begin
    state_d     = state_q;
    cmd_ready   = 1'b0;
    mosi_tvalid = 1'b0;
    rsp_valid   = 1'b0;
    rx_last     = miso_hs && (rx_cnt_q == CW'(NBYTES - 1));
    // Abort on the cycle the timer would reach TIMEOUT_CYCLES-1; a miso byte in that cycle rescues the command.
    timeout     = !miso_hs && (timer_q == TW'(TIMEOUT_CYCLES - 2));
    case (state_q)
      IDLE: begin
        cmd_ready = !reset;
        if (cmd_valid) state_d = XFER;
      end
      XFER: begin
        mosi_tvalid = (tx_cnt_q < CW'(NBYTES));
        if (rx_last || timeout) state_d = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register, shift registers, byte counters and the inter-byte timer.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      tx_sr_q  <= '0;
      rdata_q  <= '0;
      tx_cnt_q <= '0;
      rx_cnt_q <= '0;
      timer_q  <= '0;
      write_q  <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (cmd_valid) begin
            write_q  <= cmd_write;
            tx_sr_q  <= {build_addr_byte(cmd_write, READ_BIT_VALUE, cmd_addr), wdata_sel};
            tx_cnt_q <= '0;
            rx_cnt_q <= '0;
            timer_q  <= '0;
            rdata_q  <= '0;
            error_q  <= 1'b0;
          end
        end
        XFER: begin
          if (mosi_hs) begin
            tx_sr_q  <= tx_sr_q << SPI_BYTE_WIDTH;
            tx_cnt_q <= tx_cnt_q + CW'(1);
          end
          if (miso_hs) begin
            rx_cnt_q <= rx_cnt_q + CW'(1);
            timer_q  <= '0;
            // The byte clocked back during the address slot carries no data.
            if ((rx_cnt_q != '0) && !write_q) begin
              rdata_q <= (rdata_q << SPI_BYTE_WIDTH) | DW'(miso_tdata);
            end
          end else begin
            timer_q <= timer_q + TW'(1);
          end
          if (timeout) begin
            error_q <= 1'b1;
            rdata_q <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_register_controller.sv
// Self-checking bench: register-file SPI slave model, per-cycle output comparison and directed plus random commands.
// Latency: checks 1-cycle response after last miso byte and 64-cycle timeout.
// Backpressure: random and forced stalls on mosi_tready and rsp_ready.
module tb_spi_register_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [6:0]  cmd_addr;
  logic [15:0] cmd_wdata, rsp_rdata;
  logic        rsp_valid, rsp_ready, rsp_error;
  logic [7:0]  mosi_tdata, miso_tdata;
  logic        mosi_tvalid, mosi_tready, mosi_tkeep, mosi_tlast, mosi_tid, mosi_tdest, mosi_tuser;
  logic        miso_tvalid, miso_tready;

  always #5 clk = ~clk;

  spi_register_controller #(
    .ADDR_WIDTH(7), .DATA_BYTES(2), .READ_BIT_VALUE(1'b1), .TIMEOUT_CYCLES(64)
  ) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
    .mosi_tdata(mosi_tdata), .mosi_tvalid(mosi_tvalid), .mosi_tready(mosi_tready),
    .mosi_tkeep(mosi_tkeep), .mosi_tlast(mosi_tlast), .mosi_tid(mosi_tid),
    .mosi_tdest(mosi_tdest), .mosi_tuser(mosi_tuser),
    .miso_tdata(miso_tdata), .miso_tvalid(miso_tvalid), .miso_tready(miso_tready)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
  endtask

  // Expectations built from the command stream.
  logic [7:0]  exp_mosi[$];
  logic [15:0] exp_rdata[$];
  bit          exp_err[$];
  logic [15:0] exp_regs[128];

  // Slave model state and controls.
  logic [15:0] slv_regs[128];
  logic [7:0]  mosi_log[$];
  logic [7:0]  resp_q[$];
  int  mosi_pct = 100, miso_pct = 100, rsp_pct = 100;
  bit  mosi_stall = 1'b0, rsp_stall = 1'b0;
  int  miso_limit = 1 << 30;
  int  mosi_cnt = 0, miso_sent = 0;
  int  fidx = 0;
  bit  s_rd;
  logic [6:0]  s_addr;
  logic [15:0] wacc;

  // Results captured by the compare process.
  logic [15:0] last_rdata = '0;
  bit          last_err = 1'b0;

  // Register-file slave: reply to each frame byte as a real SPI peripheral would.
  task automatic slave_byte(input logic [7:0] b);
    logic [15:0] r;
    if (fidx == 0) begin
      s_addr = b[6:0];
      s_rd   = b[7];
      resp_q.push_back(8'hFF);
    end else if (s_rd) begin
      r = slv_regs[s_addr];
      resp_q.push_back(fidx == 1 ? r[15:8] : r[7:0]);
    end else begin
      wacc = {wacc[7:0], b};
      resp_q.push_back(8'hA5);
    end
    fidx++;
    if (fidx == 3) begin
      if (!s_rd) slv_regs[s_addr] = wacc;
      fidx = 0;
    end
  endtask

  initial begin : periph
    bit s_rst, s_mosi, s_miso;
    logic [7:0] s_mdat;
    mosi_tready = 1'b0; miso_tvalid = 1'b0; miso_tdata = 8'h00; rsp_ready = 1'b0;
    forever begin
      @(negedge clk);
      s_rst  = reset;
      s_mosi = mosi_tvalid && mosi_tready;
      s_mdat = mosi_tdata;
      s_miso = miso_tvalid && miso_tready;
      @(posedge clk); #1;
      if (s_rst) begin
        resp_q.delete();
        fidx = 0;
      end else begin
        if (s_miso) begin
          void'(resp_q.pop_front());
          miso_sent++;
        end
        if (s_mosi) begin
          mosi_log.push_back(s_mdat);
          mosi_cnt++;
          slave_byte(s_mdat);
        end
      end
      mosi_tready = !mosi_stall && ($urandom_range(99) < mosi_pct);
      miso_tvalid = (resp_q.size() > 0) && (miso_sent < miso_limit) && ($urandom_range(99) < miso_pct);
      miso_tdata  = miso_tvalid ? resp_q[0] : 8'h00;
      rsp_ready   = !rsp_stall && ($urandom_range(99) < rsp_pct);
    end
  end

  initial begin : compare
    int cyc = 0;
    int last_miso_cyc = -1000;
    bit prev_hold = 1'b0, prev_rsp_vld = 1'b0, prev_rsp_hs = 1'b0;
    logic [7:0] prev_dat = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (reset) begin
        exp_mosi.delete(); exp_rdata.delete(); exp_err.delete();
        prev_hold = 1'b0; prev_rsp_vld = 1'b0; prev_rsp_hs = 1'b0;
        last_miso_cyc = -1000;
        continue;
      end
      chk("miso_tready", 32'(miso_tready), 32'h1);
      if (prev_hold) begin
        chk("mosi_hold_vld", 32'(mosi_tvalid), 32'h1);
        chk("mosi_hold_dat", 32'(mosi_tdata), 32'(prev_dat));
      end
      if (mosi_tvalid) begin
        chk("mosi_side", 32'({mosi_tkeep, mosi_tlast, mosi_tid, mosi_tdest, mosi_tuser}), 32'b11000);
        if (mosi_tready) begin
          if (exp_mosi.size() == 0) chk("mosi_extra", 32'(mosi_tdata), 32'hxxxx_xxxx);
          else chk("mosi_byte", 32'(mosi_tdata), 32'(exp_mosi.pop_front()));
        end
      end
      if (prev_rsp_hs) chk("cmd_ready_after_rsp", 32'(cmd_ready), 32'h1);
      if (rsp_valid) begin
        chk("cmd_ready_in_rsp", 32'(cmd_ready), 32'h0);
        chk("mosi_vld_in_rsp", 32'(mosi_tvalid), 32'h0);
        if (exp_err.size() == 0) begin
          chk("rsp_unexpected", 32'(rsp_valid), 32'h0);
        end else begin
          if (!prev_rsp_vld)
            chk("rsp_latency", 32'(cyc - last_miso_cyc), exp_err[0] ? 32'd64 : 32'd1);
          chk("rsp_rdata", 32'(rsp_rdata), 32'(exp_rdata[0]));
          chk("rsp_error", 32'(rsp_error), 32'(exp_err[0]));
          if (rsp_ready) begin
            last_rdata = rsp_rdata;
            last_err   = rsp_error;
            void'(exp_rdata.pop_front());
            void'(exp_err.pop_front());
          end
        end
      end
      if (miso_tvalid && miso_tready) last_miso_cyc = cyc;
      prev_hold    = mosi_tvalid && !mosi_tready;
      prev_dat     = mosi_tdata;
      prev_rsp_vld = rsp_valid;
      prev_rsp_hs  = rsp_valid && rsp_ready;
    end
  end

  task automatic do_cmd(input bit wr, input logic [6:0] a, input logic [15:0] wd, input bit expect_to);
    bit got = 1'b0;
    exp_mosi.push_back(wr ? {1'b0, a} : {1'b1, a});
    exp_mosi.push_back(wr ? wd[15:8] : 8'h00);
    exp_mosi.push_back(wr ? wd[7:0] : 8'h00);
    exp_err.push_back(expect_to);
    exp_rdata.push_back((wr || expect_to) ? 16'h0000 : exp_regs[a]);
    if (wr && !expect_to) exp_regs[a] = wd;
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = wd;
    for (int i = 0; i < 500 && !got; i++) begin
      @(negedge clk);
      if (cmd_ready) got = 1'b1;
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0; cmd_write = 1'($urandom); cmd_wdata = 16'($urandom);
    chk("cmd_accept", 32'(got), 32'h1);
  endtask

  task automatic wait_idle();
    bit done = 1'b0;
    for (int i = 0; i < 3000 && !done; i++) begin
      @(negedge clk);
      if (exp_err.size() == 0 && exp_mosi.size() == 0) done = 1'b1;
    end
    chk("drain", 32'(done), 32'h1);
  endtask

  task automatic wait_mosi(input int target);
    bit got = 1'b0;
    for (int i = 0; i < 500 && !got; i++) begin
      @(negedge clk);
      if (mosi_cnt >= target) got = 1'b1;
    end
    chk("wait_mosi", 32'(got), 32'h1);
  endtask

  task automatic wait_rsp_valid();
    bit got = 1'b0;
    for (int i = 0; i < 500 && !got; i++) begin
      @(negedge clk);
      if (rsp_valid) got = 1'b1;
    end
    chk("wait_rsp", 32'(got), 32'h1);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int base;
    reset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    for (int i = 0; i < 128; i++) begin
      slv_regs[i] = 16'($urandom);
      exp_regs[i] = slv_regs[i];
    end
    slv_regs[5] = 16'hCAFE;
    exp_regs[5] = 16'hCAFE;

    // Reset values.
    repeat (2) @(negedge clk);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'h0);
    chk("rst_mosi_vld", 32'(mosi_tvalid), 32'h0);
    chk("rst_rsp_vld", 32'(rsp_valid), 32'h0);
    chk("rst_rdata", 32'(rsp_rdata), 32'h0);
    chk("rst_error", 32'(rsp_error), 32'h0);
    chk("rst_miso_rdy", 32'(miso_tready), 32'h1);
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("idle_cmd_ready", 32'(cmd_ready), 32'h1);

    // Write 0x12 <- 0xBEEF.
    base = mosi_log.size();
    do_cmd(1'b1, 7'h12, 16'hBEEF, 1'b0);
    wait_idle();
    chk("wr_byte0", 32'(mosi_log[base]), 32'h12);
    chk("wr_byte1", 32'(mosi_log[base+1]), 32'hBE);
    chk("wr_byte2", 32'(mosi_log[base+2]), 32'hEF);
    chk("wr_rsp", 32'({last_err, last_rdata}), 32'h0);

    // Read 0x05 -> 0xCAFE.
    base = mosi_log.size();
    do_cmd(1'b0, 7'h05, 16'h0000, 1'b0);
    wait_idle();
    chk("rd_byte0", 32'(mosi_log[base]), 32'h85);
    chk("rd_byte1", 32'(mosi_log[base+1]), 32'h00);
    chk("rd_byte2", 32'(mosi_log[base+2]), 32'h00);
    chk("rd_rsp", 32'({last_err, last_rdata}), 32'h0CAFE);

    // mosi stalled 20 cycles mid-frame, response held 10 cycles.
    @(negedge clk);
    rsp_stall = 1'b1;
    base = mosi_cnt;
    do_cmd(1'b1, 7'h33, 16'h1234, 1'b0);
    wait_mosi(base + 1);
    mosi_stall = 1'b1;
    repeat (20) @(negedge clk);
    mosi_stall = 1'b0;
    wait_rsp_valid();
    repeat (10) @(negedge clk);
    rsp_stall = 1'b0;
    wait_idle();
    do_cmd(1'b0, 7'h33, 16'h0000, 1'b0);
    wait_idle();
    chk("stall_readback", 32'(last_rdata), 32'h1234);

    // Only two of three miso bytes delivered: timeout, then late byte dropped.
    @(negedge clk);
    miso_limit = miso_sent + 2;
    do_cmd(1'b0, 7'h05, 16'h0000, 1'b1);
    wait_idle();
    chk("to_error", 32'(last_err), 32'h1);
    chk("to_rdata", 32'(last_rdata), 32'h0);
    miso_limit = 1 << 30;
    repeat (6) @(negedge clk);
    do_cmd(1'b0, 7'h05, 16'h0000, 1'b0);
    wait_idle();
    chk("after_to_read", 32'({last_err, last_rdata}), 32'h0CAFE);

    // Reset after the second mosi byte.
    @(negedge clk);
    base = mosi_cnt;
    do_cmd(1'b0, 7'h05, 16'h0000, 1'b0);
    wait_mosi(base + 2);
    @(posedge clk); #1 reset = 1'b1;
    @(negedge clk);
    chk("midrst_cmd_ready", 32'(cmd_ready), 32'h0);
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("midrst_mosi_vld", 32'(mosi_tvalid), 32'h0);
    chk("midrst_rsp_vld", 32'(rsp_valid), 32'h0);
    chk("midrst_cmd_ready_after", 32'(cmd_ready), 32'h1);
    repeat (3) @(negedge clk);

    // Back-to-back random commands with random backpressure.
    mosi_pct = 60; miso_pct = 70; rsp_pct = 50;
    for (int i = 0; i < 10; i++) begin
      do_cmd(1'($urandom), 7'(7'h40 + $urandom_range(7)), 16'($urandom), 1'b0);
    end
    wait_idle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
